// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multi-cycle MIPS control path
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_RD    = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WR    = 4'd6,
      S_R_EXEC    = 4'd7,
      S_R_WB      = 4'd8,
      S_BRANCH    = 4'd9,
      S_JUMP      = 4'd10,
      S_ADDI_EXEC = 4'd11,
      S_ADDI_WB   = 4'd12,
      S_HALT      = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;
   localparam logic [1:0] ALUOP_ADDI = 2'b11;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   function automatic logic is_legal(input logic [5:0] op);
      return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
   endfunction

endpackage

// File: rtl/mips_retire_counter.sv
// mips_retire_counter: wrapping retired-instruction counter
module mips_retire_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q, count_d;

   // advance by one per retirement, wrapping at 2^CNT_W
   always_comb count_d = en ? count_q + CNT_W'(1) : count_q;

   // counter register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;

   assign count = count_q;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM of the multi-cycle MIPS core
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter bit ILLEGAL_HALT = 1'b1,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             pc_en,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic             illegal_op,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   state_t state_q, state_d;
   logic   retire;

   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;

   // next state and retirement strobe (retire marks the edge that completes an instruction)
   always_comb begin
      state_d = S_IDLE;
      retire  = 1'b0;
      case (state_q)
         S_IDLE:      state_d = S_FETCH;
         S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:
            case (opcode)
               OP_RTYPE:     state_d = S_R_EXEC;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDI_EXEC;
               default: begin
                  state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
                  retire  = !ILLEGAL_HALT;
               end
            endcase
         S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:    state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
         S_MEM_WB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_MEM_WR: begin
            state_d = mem_ready ? S_FETCH : S_MEM_WR;
            retire  = mem_ready;
         end
         S_R_EXEC:    state_d = S_R_WB;
         S_ADDI_EXEC: state_d = S_ADDI_WB;
         S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_HALT:      state_d = S_HALT;
         default:     state_d = S_IDLE;
      endcase
   end

   // control outputs decoded from state; FETCH strobes wait for the memory
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      alu_op        = ALUOP_ADD;
      pc_source     = PCSRC_ALU;
      illegal_op    = 1'b0;
      halted        = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b  = SRCB_IMM_SH2;
            illegal_op = !is_legal(opcode);
         end
         S_MEM_ADDR, S_ADDI_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = (state_q == S_ADDI_EXEC) ? ALUOP_ADDI : ALUOP_ADD;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNC;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
         end
         S_ADDI_WB: reg_write = 1'b1;
         S_HALT:    halted    = 1'b1;
         default: ;
      endcase
   end

   assign pc_en = pc_write | (pc_write_cond & zero);

   mips_retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (retire),
      .count (retired)
   );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: scoreboarded directed test of both illegal-opcode policies
module tb_mips_multicycle_ctrl;

   localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MADDR = 3, ST_MRD = 4,
                  ST_MWB = 5, ST_MWR = 6, ST_REXEC = 7, ST_RWB = 8, ST_BR = 9,
                  ST_J = 10, ST_AEXEC = 11, ST_AWB = 12, ST_HALT = 13;

   localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                          BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, ILL = 6'b111111;

   typedef struct {
      logic [5:0]  op;
      logic        mr;
      logic        z;
      logic [18:0] ea;
      logic [18:0] eb;
   } step_t;

   logic clk = 1'b0, rst_n, zero, mem_ready;
   logic [5:0] opcode;

   logic pw_a, pwc_a, pen_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rdst_a, rw_a, sa_a, ill_a, hlt_a;
   logic [1:0] sb_a, ao_a, ps_a;
   logic [31:0] ret_a;
   logic pw_b, pwc_b, pen_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rdst_b, rw_b, sa_b, ill_b, hlt_b;
   logic [1:0] sb_b, ao_b, ps_b;
   logic [1:0] ret_b;

   logic [18:0] o_a, o_b;
   assign o_a = {pw_a, pwc_a, pen_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rdst_a, rw_a, sa_a, sb_a, ao_a, ps_a, ill_a, hlt_a};
   assign o_b = {pw_b, pwc_b, pen_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rdst_b, rw_b, sa_b, sb_b, ao_b, ps_b, ill_b, hlt_b};

   step_t q[$];
   int checks = 0, errs = 0, stepno = 0;
   logic [31:0] r_a;
   logic [1:0]  r_b;

   always #5 clk = ~clk;

   mips_multicycle_ctrl #(.ILLEGAL_HALT(1'b1), .CNT_W(32)) dut_a (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pw_a), .pc_write_cond(pwc_a), .pc_en(pen_a), .iord(iord_a), .mem_read(mrd_a),
      .mem_write(mwr_a), .ir_write(irw_a), .mem_to_reg(m2r_a), .reg_dst(rdst_a), .reg_write(rw_a),
      .alu_src_a(sa_a), .alu_src_b(sb_a), .alu_op(ao_a), .pc_source(ps_a), .illegal_op(ill_a),
      .halted(hlt_a), .retired(ret_a));

   mips_multicycle_ctrl #(.ILLEGAL_HALT(1'b0), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pw_b), .pc_write_cond(pwc_b), .pc_en(pen_b), .iord(iord_b), .mem_read(mrd_b),
      .mem_write(mwr_b), .ir_write(irw_b), .mem_to_reg(m2r_b), .reg_dst(rdst_b), .reg_write(rw_b),
      .alu_src_a(sa_b), .alu_src_b(sb_b), .alu_op(ao_b), .pc_source(ps_b), .illegal_op(ill_b),
      .halted(hlt_b), .retired(ret_b));

   // expected control word per state, written from the state table
   function automatic logic [18:0] ev(input int s, input logic mr, input logic z, input logic [5:0] op);
      logic pw, pwc, io, mrd, mwr, irw, m2r, rdst, rw, sa, il, hl;
      logic [1:0] sb, ao, ps;
      {pw, pwc, io, mrd, mwr, irw, m2r, rdst, rw, sa, il, hl} = '0;
      {sb, ao, ps} = '0;
      case (s)
         ST_FETCH:  begin mrd = 1; sb = 2'b01; pw = mr; irw = mr; end
         ST_DECODE: begin sb = 2'b11; il = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000}); end
         ST_MADDR:  begin sa = 1; sb = 2'b10; end
         ST_MRD:    begin mrd = 1; io = 1; end
         ST_MWB:    begin rw = 1; m2r = 1; end
         ST_MWR:    begin mwr = 1; io = 1; end
         ST_REXEC:  begin sa = 1; ao = 2'b10; end
         ST_RWB:    begin rw = 1; rdst = 1; end
         ST_BR:     begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
         ST_J:      begin pw = 1; ps = 2'b10; end
         ST_AEXEC:  begin sa = 1; sb = 2'b10; ao = 2'b11; end
         ST_AWB:    rw = 1;
         ST_HALT:   hl = 1;
         default: ;
      endcase
      return {pw, pwc, pw | (pwc & z), io, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ao, ps, il, hl};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s step %0d: observed %h expected %h", tag, stepno, obs, exp);
      end
   endtask

   task automatic add(input logic [5:0] op, input logic mr, input logic z, input int sa, input int sb);
      step_t e;
      e.op = op; e.mr = mr; e.z = z;
      e.ea = ev(sa, mr, z, op);
      e.eb = ev(sb, mr, z, op);
      q.push_back(e);
   endtask

   task automatic both(input logic [5:0] op, input logic mr, input logic z, input int s);
      add(op, mr, z, s, s);
   endtask

   // queue one complete legal instruction with optional fetch and memory wait cycles
   task automatic instr(input logic [5:0] op, input int fw, input int mw, input logic z);
      for (int i = 0; i < fw; i++) both(op, 1'b0, z, ST_FETCH);
      both(op, 1'b1, z, ST_FETCH);
      both(op, 1'b1, z, ST_DECODE);
      case (op)
         RT:   begin both(op, 1, z, ST_REXEC); both(op, 1, z, ST_RWB); end
         LW:   begin
                  both(op, 1, z, ST_MADDR);
                  for (int i = 0; i < mw; i++) both(op, 1'b0, z, ST_MRD);
                  both(op, 1, z, ST_MRD);
                  both(op, 1, z, ST_MWB);
               end
         SW:   begin
                  both(op, 1, z, ST_MADDR);
                  for (int i = 0; i < mw; i++) both(op, 1'b0, z, ST_MWR);
                  both(op, 1, z, ST_MWR);
               end
         BEQ:  both(op, 1, z, ST_BR);
         JMP:  both(op, 1, z, ST_J);
         ADDI: begin both(op, 1, z, ST_AEXEC); both(op, 1, z, ST_AWB); end
         default: ;
      endcase
      r_a = r_a + 1;
      r_b = r_b + 2'd1;
   endtask

   // drain the scoreboard one cycle per entry, comparing both DUTs mid-cycle
   task automatic run();
      step_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         opcode = e.op; mem_ready = e.mr; zero = e.z;
         #1;
         chk("ctl_halt_variant", 32'(o_a), 32'(e.ea));
         chk("ctl_nop_variant", 32'(o_b), 32'(e.eb));
         stepno++;
         @(negedge clk);
      end
   endtask

   task automatic chk_ret(input string tag);
      chk({tag, "_retired_a"}, ret_a, r_a);
      chk({tag, "_retired_b"}, 32'(ret_b), 32'(r_b));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ctl_a"}, 32'(o_a), 32'h0);
      chk({tag, "_ctl_b"}, 32'(o_b), 32'h0);
      chk({tag, "_retired_a"}, ret_a, 32'h0);
      chk({tag, "_retired_b"}, 32'(ret_b), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; opcode = RT; zero = 1'b0; mem_ready = 1'b0;
      r_a = '0; r_b = '0;
      repeat (2) @(negedge clk);
      #1;
      chk_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;
      both(RT, 1, 0, ST_IDLE);
      instr(RT, 0, 0, 1'b0);
      run(); chk_ret("rtype");
      instr(LW, 0, 2, 1'b1);
      run(); chk_ret("lw_wait2");
      instr(SW, 1, 0, 1'b0);
      run(); chk_ret("sw_fetchwait");
      instr(BEQ, 0, 0, 1'b1);
      run(); chk_ret("beq_taken");
      instr(BEQ, 0, 0, 1'b0);
      run(); chk_ret("beq_not_taken");
      instr(JMP, 0, 0, 1'b1);
      instr(ADDI, 0, 0, 1'b1);
      run(); chk_ret("j_addi_wrap");
      both(ILL, 1, 0, ST_FETCH);
      both(ILL, 1, 0, ST_DECODE);
      add(RT, 1, 0, ST_HALT, ST_FETCH);
      add(RT, 1, 0, ST_HALT, ST_DECODE);
      add(RT, 1, 0, ST_HALT, ST_REXEC);
      add(RT, 1, 0, ST_HALT, ST_RWB);
      add(RT, 1, 1, ST_HALT, ST_FETCH);
      r_b = r_b + 2'd2;
      run(); chk_ret("illegal");
      rst_n = 1'b0; mem_ready = 1'b0;
      #1;
      chk_reset("reset_from_halt");
      r_a = '0; r_b = '0;
      @(negedge clk);
      rst_n = 1'b1;
      both(SW, 1, 0, ST_IDLE);
      both(SW, 1, 0, ST_FETCH);
      both(SW, 1, 0, ST_DECODE);
      both(SW, 1, 0, ST_MADDR);
      both(SW, 0, 0, ST_MWR);
      run();
      mem_ready = 1'b0;
      #1;
      chk("mem_write_before_reset", 32'({mwr_a, mwr_b}), 32'h3);
      rst_n = 1'b0;
      #1;
      chk_reset("reset_mid_memwr");
      @(negedge clk);
      chk_reset("held_in_reset");
      rst_n = 1'b1;
      both(RT, 1, 0, ST_IDLE);
      instr(RT, 0, 0, 1'b0);
      run(); chk_ret("restart");
      $display("Simulation finished: %0d checks, %0d errors", checks, errs);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multi-cycle variant of our MIPS core. It sequences the shared ALU, memory port, IR, PC and register file across FETCH/DECODE/EXECUTE/MEM/WB cycles. It generates the 2-bit alu_op that feeds Aluctrl (00 add, 01 sub, 10 funct-decoded, 11 addi). It also counts retired instructions and traps illegal opcodes.

Parameters:
ILLEGAL_HALT, 1, 1: illegal opcode enters sticky HALT; 0: illegal opcode is treated as NOP and returns to FETCH.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
opcode  in  6  IR[31:26], valid from DECODE onward.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory handshake; access completes in a cycle where it is 1.
pc_write  out  1  unconditional PC write strobe.
pc_write_cond  out  1  branch PC write qualifier.
pc_en  out  1  pc_write | (pc_write_cond & zero); drives the PC register enable.
iord  out  1  memory address select: 0 PC, 1 ALUOut.
mem_read  out  1  memory read request.
mem_write  out  1  memory write request.
ir_write  out  1  IR load strobe.
mem_to_reg  out  1  register write data: 0 ALUOut, 1 MDR.
reg_dst  out  1  destination register: 0 rt, 1 rd.
reg_write  out  1  register file write enable.
alu_src_a  out  1  0 PC, 1 A.
alu_src_b  out  2  00 B, 01 const 4, 10 sign-extended immediate, 11 sign-extended immediate << 2.
alu_op  out  2  to Aluctrl.
pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target.
illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode.
halted  out  1  high while in HALT.
retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, retired=0. All outputs are 0 while in IDLE.
- IDLE -> FETCH on the first clk edge after rst_n deasserts.
- All control outputs are combinational from state. ir_write, pc_write and pc_en are additionally gated by mem_ready in FETCH.
- Signals not listed for a state are 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=pc_write=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target). Next state by opcode:
  - 000000 -> R_EXEC
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EXEC
  - any other -> illegal_op=1, then HALT (ILLEGAL_HALT=1) or FETCH (ILLEGAL_HALT=0).
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. -> FETCH.
- MEM_WR: mem_write=1, iord=1. Waits for mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. -> R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. -> FETCH.
- JUMP: pc_write=1, pc_source=10. -> FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11. -> ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. -> FETCH.
- HALT: all strobes 0, halted=1. Sticky until reset.
- Retirement: retired increments by 1 on the clk edge leaving MEM_WB, MEM_WR (when mem_ready=1), R_WB, BRANCH, JUMP or ADDI_WB. With ILLEGAL_HALT=0 an illegal NOP also retires. Counter wraps modulo 2^CNT_W.
- Latencies with mem_ready held at 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles. Each memory wait cycle adds 1.
- Reset asserted mid-instruction: immediate return to IDLE, with no partial writes after the reset edge.
- States are one-hot-free binary, 4 bits. Unused encodings go to IDLE.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encoding constants
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - alu_op codes (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNC=10, ALUOP_ADDI=11)
  - alu_src_b and pc_source select codes
- Aluctrl uses the same alu_op constants.
- One sub-module: mips_retire_counter, holding the enable-driven wrapping counter with async reset.

Test Plan:
- Reset release, mem_ready=1, opcode=000000: states IDLE, FETCH, DECODE, R_EXEC, R_WB, FETCH. alu_op=10 in R_EXEC. reg_write=1 and reg_dst=1 in R_WB. retired=1.
- opcode=100011 with mem_ready=0 for 2 cycles in MEM_RD: lw takes 7 cycles. mem_read=1 and iord=1 held throughout MEM_RD. MEM_WB has mem_to_reg=1. retired increments once.
- opcode=000100: zero=1 gives pc_en=1 and pc_source=01 in BRANCH. Repeat with zero=0: pc_en=0. Both cases take 3 cycles, each retires.
- opcode=001000: alu_op=11 and alu_src_b=10 in ADDI_EXEC. Then reg_write=1, reg_dst=0 in ADDI_WB.
- opcode=111111: illegal_op pulses 1 cycle. ILLEGAL_HALT=1 gives halted=1 permanently with strobes at 0 and retired unchanged. ILLEGAL_HALT=0 returns to FETCH with retired+1.
- rst_n pulled low during MEM_WR: mem_write drops immediately, state=IDLE, retired=0. The core restarts at FETCH after release.
